// File: rtl/brc_pkg.sv
// Shared types and constants for the serial byte-wise branch comparator.
package brc_pkg;

  localparam int NUM_BYTES = 4;
  localparam int BYTE_W    = 8;

  typedef logic [$clog2(NUM_BYTES)-1:0] byte_idx_t;

  localparam byte_idx_t IDX_MSB = byte_idx_t'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/brc_byte_cmp.sv
// Combinational unsigned compare of one operand byte.
module brc_byte_cmp
  import brc_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              eq,
  output logic              lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/brc_serial.sv
// Serial branch comparator: one byte per cycle, MSB first, signed or unsigned.
// Define BRC_EARLY_EXIT_EN to finish at the first unequal byte instead of always scanning 4.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready_o high
// CMP   | comparing the byte selected by idx_q
// DONE  | result presented until the consumer takes it
module brc_serial
  import brc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        br_un_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        br_equal_o,
  output logic        br_less_o
);

  state_t state_q, state_d;
  byte_idx_t idx_q;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q, b_q;
  logic un_q, eq_q, lt_q;
  logic [BYTE_W-1:0] a_byte, b_byte;
  logic byte_eq, byte_lt;
  logic accept, decide, last_byte;
  logic res_eq, res_lt;

  // Signed order equals unsigned order once the sign bits are flipped.
  always_comb begin
    a_byte = a_q[idx_q];
    b_byte = b_q[idx_q];
    if (idx_q == IDX_MSB && !un_q) begin
      a_byte[BYTE_W-1] = ~a_byte[BYTE_W-1];
      b_byte[BYTE_W-1] = ~b_byte[BYTE_W-1];
    end
  end

  brc_byte_cmp u_byte_cmp (
    .a  (a_byte),
    .b  (b_byte),
    .eq (byte_eq),
    .lt (byte_lt)
  );

  assign last_byte = (idx_q == '0);

`ifdef BRC_EARLY_EXIT_EN
  assign res_eq = byte_eq;
  assign res_lt = byte_lt;
`else
  logic found_q, found_lt_q;

  // First unequal byte from the MSB wins; later bytes are scanned but ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      found_q    <= 1'b0;
      found_lt_q <= 1'b0;
    end else if (accept) begin
      found_q    <= 1'b0;
      found_lt_q <= 1'b0;
    end else if (state_q == CMP && !found_q && !byte_eq) begin
      found_q    <= 1'b1;
      found_lt_q <= byte_lt;
    end
  end

  assign res_eq = !found_q && byte_eq;
  assign res_lt = found_q ? found_lt_q : byte_lt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    accept     = 1'b0;
    decide     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
`ifdef BRC_EARLY_EXIT_EN
        decide = !byte_eq || last_byte;
`else
        decide = last_byte;
`endif
        if (decide) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      un_q  <= 1'b0;
      idx_q <= IDX_MSB;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= rs1_data_i;
        b_q   <= rs2_data_i;
        un_q  <= br_un_i;
        idx_q <= IDX_MSB;
      end else if (state_q == CMP && !decide) begin
        idx_q <= idx_q - 1'b1;
      end
      if (decide) begin
        eq_q <= res_eq;
        lt_q <= res_lt;
      end
    end
  end

  assign out_valid_o = (state_q == DONE);
  assign br_equal_o  = eq_q;
  assign br_less_o   = lt_q;

endmodule
